// File: rtl/dpb_udp_dispatch.sv
// Queues DPB buffer-ready requests and hands them one at a time to the UDP packetizer.
// It also tracks IPv4 identification and a per-window count of frame-final packets.
module dpb_udp_dispatch #(
   parameter int DATA_W        = 128,
   parameter int RANK_W        = 4,
   parameter int WORD_W        = 7,
   parameter int QUEUE_DEPTH   = 4,
   parameter int SETTLE_CYCLES = 40,
   parameter int EN_STRETCH    = 16,
   parameter int STAT_PERIOD   = 84000000,
   localparam int BYTE_W       = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
   input  logic                     i_pclk,
   input  logic                     i_rst_n,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic [RANK_W-1:0]        i_req_buf_rank,
   input  logic [7:0]               i_req_udp_rank,
   input  logic [WORD_W-1:0]        i_req_word_cnt,
   input  logic [BYTE_W-1:0]        i_req_byte_cnt,
   input  logic                     i_req_last,
   output logic [RANK_W+WORD_W-1:0] o_dpb_addr,
   input  logic [DATA_W-1:0]        i_dpb_rd_data,
   output logic                     o_udp_en,
   output logic [DATA_W-1:0]        o_udp_data,
   output logic                     o_udp_last,
   output logic [14:0]              o_udp_frame_rank,
   output logic [15:0]              o_udp_len,
   output logic [15:0]              o_udp_ipv4_id,
   input  logic [WORD_W-1:0]        i_udp_word_idx,
   input  logic                     i_udp_busy,
   output logic                     o_done,
   output logic [RANK_W-1:0]        o_done_buf_rank,
   output logic [15:0]              o_frame_rate
);

   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int PER_W = (STAT_PERIOD > 1) ? $clog2(STAT_PERIOD) : 1;
   localparam int BPW   = DATA_W / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [RANK_W-1:0] r_qBufRank [QUEUE_DEPTH];
   logic [7:0]        r_qUdpRank [QUEUE_DEPTH];
   logic [WORD_W-1:0] r_qWordCnt [QUEUE_DEPTH];
   logic [BYTE_W-1:0] r_qByteCnt [QUEUE_DEPTH];
   logic              r_qLast    [QUEUE_DEPTH];

   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [PTR_W:0]    r_count;

   logic [1:0]        r_state;
   logic [SET_W-1:0]  r_settle;
   logic [RANK_W-1:0] r_bufRank;
   logic [7:0]        r_udpRank;
   logic [15:0]       r_len;
   logic              r_last;
   logic [15:0]       r_ipv4Id;
   logic [EN_STRETCH-1:0] r_enSr;

   logic [PER_W-1:0]  r_periodCnt;
   logic [15:0]       r_winCnt;
   logic [15:0]       r_frameRate;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [WORD_W-1:0] w_headWordCnt;
   logic [BYTE_W-1:0] w_headByteCnt;
   logic              w_headLast;
   logic [16:0]       w_wordsEff;
   logic [15:0]       w_len16;
   logic              w_statWrap;
   logic [15:0]       w_winNext;

   assign w_full  = (r_count == (PTR_W + 1)'(QUEUE_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = i_req_valid && !w_full;
   assign w_pop   = (r_state == ST_IDLE) && !w_empty && !i_udp_busy;

   assign w_headWordCnt = r_qWordCnt[r_rdPtr];
   assign w_headByteCnt = r_qByteCnt[r_rdPtr];
   assign w_headLast    = r_qLast[r_rdPtr];

   // A last packet's final word is the partial one, so it is not counted as full;
   // an empty last packet clamps to the partial byte count instead of underflowing.
   always_comb begin
      w_wordsEff = 17'(w_headWordCnt);
      if (w_headLast) begin
         w_wordsEff = (w_headWordCnt == '0) ? 17'd0 : (17'(w_headWordCnt) - 17'd1);
      end
      w_len16 = 16'(w_wordsEff * 17'(BPW) + 17'(w_headByteCnt));
   end

   always_ff @(posedge i_pclk) begin
      if (w_push) begin
         r_qBufRank[r_wrPtr] <= i_req_buf_rank;
         r_qUdpRank[r_wrPtr] <= i_req_udp_rank;
         r_qWordCnt[r_wrPtr] <= i_req_word_cnt;
         r_qByteCnt[r_wrPtr] <= i_req_byte_cnt;
         r_qLast[r_wrPtr]    <= i_req_last;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The settle counter saturates so a busy packetizer can hold ACTIVE indefinitely.
   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_settle  <= '0;
         r_bufRank <= '0;
         r_udpRank <= '0;
         r_len     <= '0;
         r_last    <= 1'b0;
         r_ipv4Id  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_bufRank <= r_qBufRank[r_rdPtr];
                  r_udpRank <= r_qUdpRank[r_rdPtr];
                  r_len     <= w_len16;
                  r_last    <= w_headLast;
                  r_settle  <= '0;
                  r_state   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (r_settle == SET_W'(SETTLE_CYCLES)) begin
                  if (!i_udp_busy) r_state <= ST_DONE;
               end else begin
                  r_settle <= r_settle + SET_W'(1);
               end
            end
            ST_DONE: begin
               r_last   <= 1'b0;
               r_ipv4Id <= r_ipv4Id + 16'd1;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_enSr <= '0;
      end else begin
         r_enSr <= (r_enSr << 1) | EN_STRETCH'(w_pop);
      end
   end

   // A dispatch in the wrap cycle still belongs to the window being closed.
   assign w_statWrap = (r_periodCnt == PER_W'(STAT_PERIOD - 1));
   assign w_winNext  = (w_pop && w_headLast && (r_winCnt != 16'hFFFF)) ? (r_winCnt + 16'd1) : r_winCnt;

   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_periodCnt <= '0;
         r_winCnt    <= '0;
         r_frameRate <= '0;
      end else if (w_statWrap) begin
         r_periodCnt <= '0;
         r_winCnt    <= '0;
         r_frameRate <= w_winNext;
      end else begin
         r_periodCnt <= r_periodCnt + PER_W'(1);
         r_winCnt    <= w_winNext;
      end
   end

   assign o_req_ready      = !w_full;
   assign o_dpb_addr       = {r_bufRank, i_udp_word_idx};
   assign o_udp_data       = i_dpb_rd_data;
   assign o_udp_en         = |r_enSr;
   assign o_udp_last       = r_last;
   assign o_udp_frame_rank = {7'd0, r_udpRank};
   assign o_udp_len        = r_len;
   assign o_udp_ipv4_id    = r_ipv4Id;
   assign o_done           = (r_state == ST_DONE);
   assign o_done_buf_rank  = (r_state == ST_DONE) ? r_bufRank : '0;
   assign o_frame_rate     = r_frameRate;

endmodule

// File: tb/tb_dpb_udp_dispatch.sv
// Self-checking bench for dpb_udp_dispatch: directed steps plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_dpb_udp_dispatch;

   localparam int SETTLE  = 40;
   localparam int STRETCH = 16;
   localparam int PERIOD  = 1000;
   localparam int DEPTH   = 4;
   localparam int BPW     = 16;

   logic         i_pclk = 1'b0;
   logic         i_rst_n;
   logic         i_req_valid;
   logic         o_req_ready;
   logic [3:0]   i_req_buf_rank;
   logic [7:0]   i_req_udp_rank;
   logic [6:0]   i_req_word_cnt;
   logic [3:0]   i_req_byte_cnt;
   logic         i_req_last;
   logic [10:0]  o_dpb_addr;
   logic [127:0] i_dpb_rd_data;
   logic         o_udp_en;
   logic [127:0] o_udp_data;
   logic         o_udp_last;
   logic [14:0]  o_udp_frame_rank;
   logic [15:0]  o_udp_len;
   logic [15:0]  o_udp_ipv4_id;
   logic [6:0]   i_udp_word_idx;
   logic         i_udp_busy;
   logic         o_done;
   logic [3:0]   o_done_buf_rank;
   logic [15:0]  o_frame_rate;

   always #5 i_pclk = ~i_pclk;

   dpb_udp_dispatch #(
      .DATA_W(128), .RANK_W(4), .WORD_W(7), .QUEUE_DEPTH(DEPTH),
      .SETTLE_CYCLES(SETTLE), .EN_STRETCH(STRETCH), .STAT_PERIOD(PERIOD)
   ) dut (
      .i_pclk(i_pclk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_buf_rank(i_req_buf_rank), .i_req_udp_rank(i_req_udp_rank),
      .i_req_word_cnt(i_req_word_cnt), .i_req_byte_cnt(i_req_byte_cnt),
      .i_req_last(i_req_last), .o_dpb_addr(o_dpb_addr),
      .i_dpb_rd_data(i_dpb_rd_data), .o_udp_en(o_udp_en),
      .o_udp_data(o_udp_data), .o_udp_last(o_udp_last),
      .o_udp_frame_rank(o_udp_frame_rank), .o_udp_len(o_udp_len),
      .o_udp_ipv4_id(o_udp_ipv4_id), .i_udp_word_idx(i_udp_word_idx),
      .i_udp_busy(i_udp_busy), .o_done(o_done),
      .o_done_buf_rank(o_done_buf_rank), .o_frame_rate(o_frame_rate)
   );

   typedef struct {
      logic [3:0] bufRank;
      logic [7:0] udpRank;
      logic [6:0] wordCnt;
      logic [3:0] byteCnt;
      logic       last;
   } req_t;

   int checks = 0;
   int errors = 0;

   // Reference model: queued requests, the packet in service and its age in cycles.
   req_t        mq[$];
   logic [3:0]  mRank;
   logic [7:0]  mUdpRank;
   logic [15:0] mLen;
   logic        mLast;
   logic [15:0] mId;
   logic [15:0] mFrameRate;
   int          mWindow;
   bit          mActive;
   bit          mDone;
   int          mAge;
   int          mEnRem;
   int          mCyc;
   bit          mPushed;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] expectLen(input req_t r);
      int words;
      if (r.last) words = (r.wordCnt == 0) ? 0 : int'(r.wordCnt) - 1;
      else        words = int'(r.wordCnt);
      return 16'((words * BPW + int'(r.byteCnt)) % 65536);
   endfunction

   function automatic req_t randReq(input logic last);
      req_t r;
      r.bufRank = 4'($urandom());
      r.udpRank = 8'($urandom());
      r.wordCnt = 7'($urandom());
      r.byteCnt = 4'($urandom());
      r.last    = last;
      return r;
   endfunction

   task automatic modelEdge();
      bit   pop;
      bit   push;
      bit   lastPop;
      bit   nextDone;
      req_t r;
      if (!i_rst_n) begin
         mq.delete();
         mRank = '0; mUdpRank = '0; mLen = '0; mLast = 1'b0; mId = '0;
         mFrameRate = '0; mWindow = 0; mActive = 0; mDone = 0;
         mAge = 0; mEnRem = 0; mCyc = 0; mPushed = 0;
         return;
      end
      push     = i_req_valid && (mq.size() < DEPTH);
      pop      = !mActive && !mDone && (mq.size() > 0) && !i_udp_busy;
      nextDone = 0;
      lastPop  = 0;
      if (mActive) begin
         if (mAge >= SETTLE + 1 && !i_udp_busy) begin
            mActive  = 0;
            nextDone = 1;
         end else begin
            mAge++;
         end
      end
      if (mDone) begin
         mId   = mId + 16'd1;
         mLast = 1'b0;
      end
      if (pop) begin
         r        = mq.pop_front();
         mRank    = r.bufRank;
         mUdpRank = r.udpRank;
         mLen     = expectLen(r);
         mLast    = r.last;
         mActive  = 1;
         mAge     = 1;
         mEnRem   = STRETCH;
         lastPop  = r.last;
      end else if (mEnRem > 0) begin
         mEnRem--;
      end
      if (push) begin
         r.bufRank = i_req_buf_rank;
         r.udpRank = i_req_udp_rank;
         r.wordCnt = i_req_word_cnt;
         r.byteCnt = i_req_byte_cnt;
         r.last    = i_req_last;
         mq.push_back(r);
      end
      mPushed = push;
      mDone   = nextDone;
      if (lastPop && mWindow < 65535) mWindow++;
      if (mCyc % PERIOD == PERIOD - 1) begin
         mFrameRate = 16'(mWindow);
         mWindow    = 0;
      end
      mCyc++;
   endtask

   task automatic compareAll();
      checkOutput("ready",      o_req_ready, (mq.size() < DEPTH));
      checkOutput("udp_en",     o_udp_en, (mEnRem > 0));
      checkOutput("done",       o_done, mDone);
      checkOutput("done_rank",  o_done_buf_rank, mDone ? mRank : 4'd0);
      checkOutput("udp_len",    o_udp_len, mLen);
      checkOutput("udp_last",   o_udp_last, mLast);
      checkOutput("frame_rank", o_udp_frame_rank, {7'd0, mUdpRank});
      checkOutput("ipv4_id",    o_udp_ipv4_id, mId);
      checkOutput("frame_rate", o_frame_rate, mFrameRate);
      checkOutput("dpb_addr",   o_dpb_addr, {mRank, i_udp_word_idx});
      checkOutput("udp_data",   o_udp_data, i_dpb_rd_data);
   endtask

   task automatic tick();
      @(posedge i_pclk);
      modelEdge();
      #1;
      compareAll();
      i_udp_word_idx = 7'($urandom());
      i_dpb_rd_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic driveReq(input req_t r);
      i_req_buf_rank = r.bufRank;
      i_req_udp_rank = r.udpRank;
      i_req_word_cnt = r.wordCnt;
      i_req_byte_cnt = r.byteCnt;
      i_req_last     = r.last;
   endtask

   task automatic applyStimulus(input req_t r, input string tag);
      bit accepted;
      accepted = 0;
      driveReq(r);
      i_req_valid = 1'b1;
      for (int k = 0; k < 500; k++) begin
         tick();
         if (mPushed) begin
            accepted = 1;
            break;
         end
      end
      i_req_valid = 1'b0;
      checkOutput({tag, "_accepted"}, accepted, 1'b1);
   endtask

   task automatic waitPop(input string tag);
      bit seen;
      seen = 0;
      for (int k = 0; k < 600; k++) begin
         tick();
         if (mActive && mAge == 1) begin
            seen = 1;
            break;
         end
      end
      checkOutput({tag, "_popped"}, seen, 1'b1);
   endtask

   task automatic pulseReset();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
   endtask

   initial begin
      req_t       r;
      req_t       r2;
      logic [3:0] burstRanks[5];
      logic [3:0] gotRanks[$];
      int         guard;

      i_rst_n = 1'b0; i_req_valid = 1'b0; i_udp_busy = 1'b0;
      i_req_buf_rank = '0; i_req_udp_rank = '0; i_req_word_cnt = '0;
      i_req_byte_cnt = '0; i_req_last = 1'b0;
      i_udp_word_idx = '0; i_dpb_rd_data = '0;

      $display("[TB] reset");
      ticks(3);
      checkOutput("rst_ready", o_req_ready, 1'b1);
      checkOutput("rst_done", o_done, 1'b0);
      checkOutput("rst_id", o_udp_ipv4_id, 16'd0);
      i_rst_n = 1'b1;
      tick();

      $display("[TB] single request");
      r = '{4'd3, 8'd5, 7'd10, 4'd0, 1'b0};
      applyStimulus(r, "single");
      waitPop("single");
      checkOutput("single_len", o_udp_len, 16'd160);
      checkOutput("single_frame_rank", o_udp_frame_rank, 15'd5);
      checkOutput("single_en_first", o_udp_en, 1'b1);
      checkOutput("single_id_before", o_udp_ipv4_id, 16'd0);
      ticks(15);
      checkOutput("single_en_last", o_udp_en, 1'b1);
      tick();
      checkOutput("single_en_off", o_udp_en, 1'b0);
      ticks(24);
      checkOutput("single_done_early", o_done, 1'b0);
      tick();
      checkOutput("single_done", o_done, 1'b1);
      checkOutput("single_done_rank", o_done_buf_rank, 4'd3);
      tick();
      checkOutput("single_id_after", o_udp_ipv4_id, 16'd1);

      $display("[TB] last packets");
      r = '{4'($urandom()), 8'd9, 7'd4, 4'd7, 1'b1};
      applyStimulus(r, "last");
      waitPop("last");
      checkOutput("last_len", o_udp_len, 16'd55);
      checkOutput("last_flag", o_udp_last, 1'b1);
      ticks(41);
      checkOutput("last_flag_in_done", o_udp_last, 1'b1);
      tick();
      checkOutput("last_flag_cleared", o_udp_last, 1'b0);
      r = '{4'($urandom()), 8'd10, 7'd0, 4'd9, 1'b1};
      applyStimulus(r, "clamp");
      waitPop("clamp");
      checkOutput("clamp_len", o_udp_len, 16'd9);
      ticks(45);

      $display("[TB] burst of five");
      i_udp_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         burstRanks[i] = 4'(i * 3 + 1);
      end
      for (int i = 0; i < 4; i++) begin
         r = randReq(1'($urandom()));
         r.bufRank = burstRanks[i];
         applyStimulus(r, "burst");
      end
      checkOutput("burst_full", o_req_ready, 1'b0);
      r = randReq(1'b0);
      r.bufRank = burstRanks[4];
      driveReq(r);
      i_req_valid = 1'b1;
      ticks(3);
      checkOutput("burst_held", o_req_ready, 1'b0);
      i_udp_busy = 1'b0;
      gotRanks.delete();
      guard = 0;
      while (gotRanks.size() < 5 && guard < 600) begin
         tick();
         if (mPushed) i_req_valid = 1'b0;
         if (o_done) gotRanks.push_back(o_done_buf_rank);
         guard++;
      end
      i_req_valid = 1'b0;
      checkOutput("burst_done_count", gotRanks.size(), 5);
      for (int i = 0; i < 5 && i < gotRanks.size(); i++) begin
         checkOutput("burst_order", gotRanks[i], burstRanks[i]);
      end

      $display("[TB] busy hold");
      r  = randReq(1'b0);
      r2 = randReq(1'b0);
      applyStimulus(r, "busy");
      waitPop("busy");
      driveReq(r2);
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
      ticks(8);
      i_udp_busy = 1'b1;
      ticks(91);
      checkOutput("busy_no_done", o_done, 1'b0);
      checkOutput("busy_no_pop", o_udp_frame_rank, {7'd0, r.udpRank});
      i_udp_busy = 1'b0;
      tick();
      checkOutput("busy_done", o_done, 1'b1);
      i_udp_busy = 1'b1;
      ticks(6);
      checkOutput("busy_idle_block", o_udp_en, 1'b0);
      i_udp_busy = 1'b0;
      waitPop("busy_second");
      checkOutput("busy_second_rank", o_udp_frame_rank, {7'd0, r2.udpRank});
      ticks(45);

      $display("[TB] random traffic");
      for (int k = 0; k < 800; k++) begin
         driveReq(randReq(1'($urandom())));
         i_req_valid = ($urandom_range(0, 2) == 0);
         i_udp_busy  = ($urandom_range(0, 15) == 0);
         tick();
      end
      i_req_valid = 1'b0;
      i_udp_busy  = 1'b0;
      ticks(50);

      $display("[TB] statistics window");
      pulseReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(randReq(1'b1), "stat");
      end
      guard = 0;
      while (mCyc < PERIOD && guard < 3000) begin
         tick();
         guard++;
      end
      checkOutput("stat_rate_3", o_frame_rate, 16'd3);
      guard = 0;
      while (mCyc < 2 * PERIOD && guard < 3000) begin
         tick();
         guard++;
      end
      checkOutput("stat_rate_0", o_frame_rate, 16'd0);

      $display("[TB] reset mid-active");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(randReq(1'b0), "mid");
      end
      ticks(5);
      i_rst_n = 1'b0;
      tick();
      checkOutput("mid_ready", o_req_ready, 1'b1);
      checkOutput("mid_en", o_udp_en, 1'b0);
      checkOutput("mid_done", o_done, 1'b0);
      checkOutput("mid_len", o_udp_len, 16'd0);
      checkOutput("mid_id", o_udp_ipv4_id, 16'd0);
      i_rst_n = 1'b1;
      ticks(60);
      checkOutput("mid_empty", o_udp_en, 1'b0);
      r = randReq(1'b0);
      applyStimulus(r, "fresh");
      waitPop("fresh");
      checkOutput("fresh_id", o_udp_ipv4_id, 16'd0);
      checkOutput("fresh_rank", o_udp_frame_rank, {7'd0, r.udpRank});
      ticks(41);
      checkOutput("fresh_done", o_done, 1'b1);
      tick();
      checkOutput("fresh_id_after", o_udp_ipv4_id, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dpb_udp_dispatch.md
# dpb_udp_dispatch

Parametrised successor to the single-slot DPB-to-UDP command block. It accepts buffer-ready requests from the DDR3/DPB write side into a QUEUE_DEPTH-entry FIFO and drains them one at a time into the UDP packetizer. For each packet it computes the payload length, drives the DPB read address from the packetizer's word index, and releases the buffer with a done pulse. It adds a per-packet IPv4 identification counter and a once-per-period frame-rate statistic.

## Interface
- DATA_W, 128, DPB/UDP data width (multiple of 8)
- RANK_W, 4, buffer-rank width (number of DPB buffers = 2^RANK_W)
- WORD_W, 7, word-index width within one buffer
- QUEUE_DEPTH, 4, request FIFO depth (power of 2, ≥2)
- SETTLE_CYCLES, 40, minimum ACTIVE cycles before completion
- EN_STRETCH, 16, o_udp_en high time in cycles
- STAT_PERIOD, 84000000, statistics window in i_pclk cycles
- i_pclk  in  1  clock
- i_rst_n  in  1  reset: one clock; reset is synchronous and active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  queue not full
- i_req_buf_rank  in  RANK_W  DPB buffer holding the packet
- i_req_udp_rank  in  8  packet index within frame
- i_req_word_cnt  in  WORD_W  DATA_W words written
- i_req_byte_cnt  in  log2(DATA_W/8)  valid bytes in the final partial word
- i_req_last  in  1  last packet of the JPEG frame
- o_dpb_addr  out  RANK_W+WORD_W  {active buf_rank, i_udp_word_idx}
- i_dpb_rd_data  in  DATA_W  DPB port-B read data
- o_udp_en  out  1  packet start (stretched)
- o_udp_data  out  DATA_W  equals i_dpb_rd_data (combinational)
- o_udp_last  out  1  last-frame flag of active packet
- o_udp_frame_rank  out  15  {7'd0, udp_rank}
- o_udp_len  out  16  payload byte length
- o_udp_ipv4_id  out  16  IPv4 identification
- i_udp_word_idx  in  WORD_W  word index requested by the packetizer
- i_udp_busy  in  1  packetizer transmitting
- o_done  out  1  one-cycle buffer release
- o_done_buf_rank  out  RANK_W  rank released by o_done
- o_frame_rate  out  16  last-flag packets in the previous STAT_PERIOD window

## Operation
- FIFO: push on i_req_valid && o_req_ready. o_req_ready = !full, so there is no push while full, even with a simultaneous pop. Push and pop in the same cycle are legal when not full. Pointers wrap modulo QUEUE_DEPTH.
- FSM IDLE -> ACTIVE -> DONE -> IDLE.
- IDLE: when the FIFO is non-empty and !i_udp_busy, pop the head and latch buf_rank, udp_rank, last and len into output registers. Pulse the internal en_start; go to ACTIVE with settle counter = 0.
- Length rule: len = (last ? word_cnt−1 : word_cnt) × (DATA_W/8) + byte_cnt. Compute in 17 bits, truncate to 16. If last and word_cnt = 0, len = byte_cnt (clamp, no underflow).
- ACTIVE: the settle counter increments and saturates at SETTLE_CYCLES. Exit to DONE when counter == SETTLE_CYCLES && !i_udp_busy.
- DONE: o_done = 1 with o_done_buf_rank = latched rank. Clear o_udp_last. Increment o_udp_ipv4_id (wraps 0xFFFF -> 0). Return to IDLE.
- o_udp_en = OR of a shift register loaded with en_start, so it is high for exactly EN_STRETCH cycles.
- Statistics: a period counter counts 0..STAT_PERIOD−1.
  - On wrap, o_frame_rate <= window count (including any dispatch in that same cycle) and the window count is cleared.
  - The window count increments on each IDLE pop with last = 1 and saturates at 0xFFFF.

## Timing
- Reset values:
  - all outputs 0 except o_req_ready = 1
  - FIFO empty, FSM IDLE, counters and en shift register 0
- Reset mid-operation discards queued requests and the active packet. No o_done is issued.
- Pop in IDLE at cycle t, which requires the entry pushed by cycle t−1 (1-cycle FIFO latency):
  - o_udp_* fields valid from t+1
  - o_udp_en high t+1..t+EN_STRETCH
  - earliest o_done at t+SETTLE_CYCLES+2
  - next pop no earlier than t+SETTLE_CYCLES+3
- o_dpb_addr is combinational from the latched rank and i_udp_word_idx. DPB read latency is owned by the packetizer.
- i_udp_busy high in IDLE blocks the pop. Busy high in ACTIVE after saturation holds the FSM in ACTIVE indefinitely.

## Test plan
- Single request: rank 3, udp_rank 5, word_cnt 10, byte_cnt 0, last 0 -> o_udp_len 160, frame_rank 5, o_udp_en 16 cycles, o_done at t+42 with rank 3, ipv4_id 0 -> 1.
- Last packet: word_cnt 4, byte_cnt 7, last 1 -> o_udp_len 55, o_udp_last 1 until DONE. Variant word_cnt 0, byte_cnt 9 -> len 9.
- Burst of 5 back-to-back requests with depth 4:
  - o_req_ready low after 4 accepts
  - 5th held until the first pop
  - all 5 dispatched in order, o_done ranks matching the input order
- Busy hold: assert i_udp_busy from t+10 to t+100 -> o_done at t+102; a queued request is not popped before busy falls.
- Stats with STAT_PERIOD = 1000: 3 last-flag packets in window 1 -> o_frame_rate 3 at cycle 1000; 0 in the next window -> 0.
- Reset asserted mid-ACTIVE with 2 queued -> next cycle all outputs at reset values, FIFO empty, no o_done; a fresh request after release dispatches with ipv4_id 0.
